// File: rtl/ram8_16_if.sv
// Bus bundle for the ram8_16 register bank: write/read/clear requests in,
// registered read data, read strobe and clear-busy flag out.
interface ram8_16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic [2:0]       address;
    logic             load;
    logic             rd_en;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output in, address, load, rd_en, clr,
        input  out, out_valid, busy
    );

    modport slave (
        input  in, address, load, rd_en, clr,
        output out, out_valid, busy
    );
endinterface

// File: rtl/ram8_16.sv
// 8-word register bank with registered read port and self-timed clear sequencer.
// Optional macro RAM8_16_BYPASS_EN: same-edge load+read forwards write data to out.
module ram8_16 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    ram8_16_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       clr_cnt_reg, clr_cnt_next;
    logic [WIDTH-1:0] word_reg [8];
    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;

    logic             idle;
    logic             clearing;
    logic             wr_fire;
    logic             rd_fire;
    logic [7:0]       wr_onehot;
    logic [7:0]       clr_onehot;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rd_src;

    // State register and clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            clr_cnt_reg <= 3'd0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Next-state logic; a clr seen while already clearing does not restart the count
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clr) begin
                    state_next   = CLEAR;
                    clr_cnt_next = 3'd0;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 3'd1;
                if (clr_cnt_reg == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = 3'd0;
            end
        endcase
    end

    // Output / strobe decode
    always_comb begin
        idle     = (state_reg == IDLE);
        clearing = (state_reg == CLEAR);
        wr_fire  = idle && !bus.clr && bus.load;
        rd_fire  = idle && !bus.clr && bus.rd_en;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign wr_onehot[gi]  = wr_fire  && (bus.address == 3'(gi));
            assign clr_onehot[gi] = clearing && (clr_cnt_reg == 3'(gi));
        end
    endgenerate

    // Word storage; async reset forces the whole bank to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                word_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (clr_onehot[i]) begin
                    word_reg[i] <= CLR_VALUE;
                end else if (wr_onehot[i]) begin
                    word_reg[i] <= bus.in;
                end
            end
        end
    end

    // 8:1 read select, sampling the pre-write contents
    always_comb begin
        rd_data = word_reg[bus.address];
`ifdef RAM8_16_BYPASS_EN
        // Read and write share one address, so a concurrent load is always a same-word hit
        rd_src = bus.load ? bus.in : rd_data;
`else
        rd_src = rd_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= rd_fire;
            if (rd_fire) begin
                out_reg <= rd_src;
            end
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = clearing;
endmodule

// File: tb/tb_ram8_16.sv
// Directed self-checking bench for ram8_16: reset, read/write, same-address
// load+read, clear sequencing, ignored inputs while busy, async reset mid-clear.
module tb_ram8_16;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ram8_16_if #(.WIDTH(16)) bus ();

    ram8_16 #(.WIDTH(16), .CLR_VALUE(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.load  = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        bus.address = a;
        bus.in      = d;
        bus.load    = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        bus.address = a;
        bus.rd_en   = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
        check(tag, {16'h0, bus.out}, {16'h0, exp});
        check({tag, "_v"}, {31'h0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        int n;
        logic [15:0] exp_same;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in      = '0;
        bus.address = '0;
        idle_in();

        // Reset state
        cyc();
        cyc();
        check("rst_out",   {16'h0, bus.out},   32'h0);
        check("rst_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_busy",  {31'h0, bus.busy},  32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic read after reset
        read_check("rd5_rst", 3'd5, 16'h0000);
        cyc();
        check("valid_drop", {31'h0, bus.out_valid}, 32'd0);

        // Write/read all words
        for (int k = 0; k < 8; k++) write_word(3'(k), 16'(16'h1111 * k));
        for (int k = 0; k < 8; k++) begin
            read_check($sformatf("rd_all%0d", k), 3'(k), 16'(16'h1111 * k));
            cyc();
            check($sformatf("hold%0d", k), {16'h0, bus.out}, {16'h0, 16'(16'h1111 * k)});
            check($sformatf("hold_v%0d", k), {31'h0, bus.out_valid}, 32'd0);
        end

        // Same-address load + read
        write_word(3'd3, 16'hAAAA);
`ifdef RAM8_16_BYPASS_EN
        exp_same = 16'h5555;
`else
        exp_same = 16'hAAAA;
`endif
        bus.address = 3'd3;
        bus.in      = 16'h5555;
        bus.load    = 1'b1;
        bus.rd_en   = 1'b1;
        cyc();
        idle_in();
        check("same_addr", {16'h0, bus.out}, {16'h0, exp_same});
        check("same_addr_v", {31'h0, bus.out_valid}, 32'd1);
        read_check("same_after", 3'd3, 16'h5555);

        // Clear sequence with a load in the acceptance cycle
        for (int k = 0; k < 8; k++) write_word(3'(k), 16'hFFFF);
        bus.clr     = 1'b1;
        bus.load    = 1'b1;
        bus.address = 3'd2;
        bus.in      = 16'h1234;
        cyc();
        idle_in();
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            cyc();
        end
        check("busy_len", 32'(n), 32'd8);
        for (int k = 0; k < 8; k++) read_check($sformatf("clr_rd%0d", k), 3'(k), 16'h0000);

        // Inputs ignored while busy
        write_word(3'd4, 16'h4444);
        read_check("pre_busy", 3'd4, 16'h4444);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check("busy_e0", {31'h0, bus.busy}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) begin
                bus.address = 3'd7;
                bus.in      = 16'h1234;
                bus.load    = 1'b1;
                bus.rd_en   = 1'b1;
                bus.clr     = 1'b1;
            end
            cyc();
            idle_in();
            if (i == 3) begin
                check("busy_out",   {16'h0, bus.out}, 32'h4444);
                check("busy_valid", {31'h0, bus.out_valid}, 32'd0);
            end
            check($sformatf("busy_e%0d", i), {31'h0, bus.busy}, 32'd1);
        end
        cyc();
        check("busy_e8", {31'h0, bus.busy}, 32'd0);
        read_check("busy_w7", 3'd7, 16'h0000);
        read_check("busy_w4", 3'd4, 16'h0000);

        // Async reset in the middle of a clear
        for (int k = 0; k < 8; k++) write_word(3'(k), 16'hBEEF);
        read_check("beef_rd", 3'd0, 16'hBEEF);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        cyc();
        cyc();
        cyc();
        check("arst_pre_busy", {31'h0, bus.busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'h0, bus.busy}, 32'd0);
        check("arst_out",   {16'h0, bus.out}, 32'h0);
        check("arst_valid", {31'h0, bus.out_valid}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("arst_idle", {31'h0, bus.busy}, 32'd0);
        for (int k = 0; k < 8; k++) read_check($sformatf("arst_rd%0d", k), 3'(k), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
